// File: rtl/mips_pkg.sv
// Purpose: shared MIPS control definitions (opcodes, ALU-op classes, control bundle).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    // Instruction opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // ALU-op class handed to the ALU control block; 2'b11 is never produced
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Control bundle shared with the datapath and ALU control
    typedef struct packed {
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    // All strobes cleared: the value held while in reset
    localparam ctrl_t CTRL_ZERO = '{
        reg_dst: 1'b0, reg_write: 1'b0, alu_src: 1'b0, mem_to_reg: 1'b0,
        mem_read: 1'b0, mem_write: 1'b0, branch: 1'b0, alu_op: ALUOP_ADD,
        illegal: 1'b0
    };

    // Unsupported opcode: safe no-op with only the illegal flag raised
    localparam ctrl_t CTRL_ILLEGAL = '{
        reg_dst: 1'b0, reg_write: 1'b0, alu_src: 1'b0, mem_to_reg: 1'b0,
        mem_read: 1'b0, mem_write: 1'b0, branch: 1'b0, alu_op: ALUOP_ADD,
        illegal: 1'b1
    };

endpackage

// File: rtl/control_decode.sv
// Purpose: combinational opcode -> control bundle decode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the opcode input.
module control_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    // Decode table; textbook don't-cares are tied to 0 so no X escapes
    always_comb begin
        ctrl = CTRL_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                ctrl         = CTRL_ZERO;
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl            = CTRL_ZERO;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                ctrl           = CTRL_ZERO;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                ctrl        = CTRL_ZERO;
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_SUB;
            end
            default: ctrl = CTRL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Purpose: main MIPS control decoder with registered strobes.
// Latency: 1 cycle (opcode sampled at rising clk, strobes valid after that edge).
// Backpressure: none; a new decode is loaded every cycle.
module control_unit
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       Branch,
    output logic       ALUOp1,
    output logic       ALUOp0,
    output logic       Illegal
);

    ctrl_t dec_ctrl;
    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    control_decode u_decode (
        .opcode (Opcode),
        .ctrl   (dec_ctrl)
    );

    // Next-state: every cycle takes the fresh decode, no hold or stall path
    always_comb begin
        ctrl_d = dec_ctrl;
    end

    // Output register; reset clears everything, including the illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= CTRL_ZERO;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign RegDst   = ctrl_q.reg_dst;
    assign RegWrite = ctrl_q.reg_write;
    assign ALUSrc   = ctrl_q.alu_src;
    assign MemtoReg = ctrl_q.mem_to_reg;
    assign MemRead  = ctrl_q.mem_read;
    assign MemWrite = ctrl_q.mem_write;
    assign Branch   = ctrl_q.branch;
    assign ALUOp1   = ctrl_q.alu_op[1];
    assign ALUOp0   = ctrl_q.alu_op[0];
    assign Illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [5:0] Opcode;
    logic RegDst, RegWrite, ALUSrc, MemtoReg, MemRead, MemWrite;
    logic Branch, ALUOp1, ALUOp0, Illegal;
    logic [9:0] outs;

    int n_tests;
    int n_fail;

    // Hand-computed patterns: RegDst,RegWrite,ALUSrc,MemtoReg,MemRead,MemWrite,Branch,ALUOp1,ALUOp0,Illegal
    localparam logic [9:0] P_R    = 10'b1100000100;
    localparam logic [9:0] P_LW   = 10'b0111100000;
    localparam logic [9:0] P_SW   = 10'b0010010000;
    localparam logic [9:0] P_BEQ  = 10'b0000001010;
    localparam logic [9:0] P_ILL  = 10'b0000000001;
    localparam logic [9:0] P_ZERO = 10'b0000000000;

    typedef struct {
        logic [5:0] op;
        logic [9:0] exp;
        string      name;
    } vec_t;

    control_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Opcode   (Opcode),
        .RegDst   (RegDst),
        .RegWrite (RegWrite),
        .ALUSrc   (ALUSrc),
        .MemtoReg (MemtoReg),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Branch   (Branch),
        .ALUOp1   (ALUOp1),
        .ALUOp0   (ALUOp0),
        .Illegal  (Illegal)
    );

    assign outs = {RegDst, RegWrite, ALUSrc, MemtoReg, MemRead, MemWrite,
                   Branch, ALUOp1, ALUOp0, Illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Apply opcode well before the edge, then sample 1 time unit after it
    task automatic step(input logic [5:0] op);
        Opcode = op;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[8];
    int   ill_count;
    logic [9:0] sweep_exp;

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{6'b000000, P_R,   "seq_rtype"};
        vecs[1] = '{6'b100011, P_LW,  "seq_lw"};
        vecs[2] = '{6'b101011, P_SW,  "seq_sw"};
        vecs[3] = '{6'b000100, P_BEQ, "seq_beq"};
        vecs[4] = '{6'b000000, P_R,   "seq_rtype2"};
        vecs[5] = '{6'b000010, P_ILL, "ill_000010"};
        vecs[6] = '{6'b111111, P_ILL, "ill_111111"};
        vecs[7] = '{6'b001000, P_ILL, "ill_001000"};

        // Reset held with lw on the bus: outputs stay 0 across edges
        rst_n  = 1'b0;
        Opcode = 6'b100011;
        #2;
        chk("reset_async", outs, P_ZERO);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_held", outs, P_ZERO);

        // Release between edges; still 0 until the next rising edge
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_release_pre_edge", outs, P_ZERO);
        @(posedge clk);
        #1;
        chk("first_edge_lw", outs, P_LW);

        // Table-driven back-to-back decode
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].op);
            chk(vecs[i].name, outs, vecs[i].exp);
        end

        // Back-to-back identical opcode holds steady
        step(6'b000100);
        step(6'b000100);
        chk("beq_repeat", outs, P_BEQ);

        // Mid-cycle opcode change has no effect until the next edge
        step(6'b101011);
        chk("latency_sw", outs, P_SW);
        #2;
        Opcode = 6'b100011;
        #1;
        chk("latency_hold_sw", outs, P_SW);
        @(posedge clk);
        #1;
        chk("latency_then_lw", outs, P_LW);

        // Async reset mid-cycle while lw is held
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_drop", outs, P_ZERO);
        Opcode = 6'b000000;
        @(posedge clk);
        #1;
        chk("midreset_hold", outs, P_ZERO);
        @(negedge clk);
        Opcode = 6'b101011;
        rst_n  = 1'b1;
        #1;
        chk("midreset_release_pre_edge", outs, P_ZERO);
        @(posedge clk);
        #1;
        chk("midreset_first_edge_sw", outs, P_SW);

        // Sweep all 64 opcodes: invariants and illegal count
        ill_count = 0;
        for (int op = 0; op < 64; op++) begin
            step(op[5:0]);
            case (op[5:0])
                6'b000000: sweep_exp = P_R;
                6'b100011: sweep_exp = P_LW;
                6'b101011: sweep_exp = P_SW;
                6'b000100: sweep_exp = P_BEQ;
                default:   sweep_exp = P_ILL;
            endcase
            chk($sformatf("sweep_op_%02h", op), outs, sweep_exp);
            chk_bit($sformatf("inv_memrw_%02h", op), MemRead & MemWrite, 1'b0);
            chk_bit($sformatf("inv_regwrite_%02h", op),
                    RegWrite & (MemWrite | Branch), 1'b0);
            chk_bit($sformatf("inv_aluop_%02h", op), ALUOp1 & ALUOp0, 1'b0);
            if (Illegal === 1'b1) ill_count++;
        end
        n_tests++;
        if (ill_count != 60) begin
            n_fail++;
            $display("FAIL illegal_count: got %0d expected 60", ill_count);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Main control decoder for the single-cycle MIPS datapath. Decodes the 6-bit instruction opcode into the nine datapath control strobes: register-file write, ALU operand select, memory read/write, branch, and the 2-bit ALU-op class sent to the ALU control block. Outputs are registered on one clock edge and cleared by an asynchronous active-low reset. An extra `Illegal` flag marks unsupported opcodes.

## Interface

Parameters: none.

- `clk` input 1 — single clock; all state updates on rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `Opcode` input 6 — instruction bits [31:26]
- `RegDst` output 1 — 1: write register is rd; 0: write register is rt
- `RegWrite` output 1 — register-file write enable
- `ALUSrc` output 1 — 1: ALU B operand is the sign-extended immediate; 0: it is rt
- `MemtoReg` output 1 — 1: write-back data comes from data memory; 0: it comes from the ALU
- `MemRead` output 1 — data-memory read enable
- `MemWrite` output 1 — data-memory write enable
- `Branch` output 1 — conditional branch (ANDed with ALU zero outside this block)
- `ALUOp1` output 1 — ALU-op class, MSB
- `ALUOp0` output 1 — ALU-op class, LSB
- `Illegal` output 1 — opcode not in the supported set

## Operation

Decode table. Fields are RegDst, RegWrite, ALUSrc, MemtoReg, MemRead, MemWrite, Branch, ALUOp1, ALUOp0, Illegal:

- R-type, 6'b000000: 1,1,0,0,0,0,0,1,0,0
- lw, 6'b100011: 0,1,1,1,1,0,0,0,0,0
- sw, 6'b101011: 0,0,1,0,0,1,0,0,0,0
- beq, 6'b000100: 0,0,0,0,0,0,1,0,1,0
- Any other opcode: all strobes 0, Illegal=1. This is a safe no-op: no register write, no memory access, no branch.

Additional rules:

- Textbook don't-cares are driven to 0: RegDst and MemtoReg for sw, RegDst for beq. No X ever reaches the outputs.
- Invariants, true in every cycle including reset:
  - MemRead and MemWrite are never both 1.
  - RegWrite=1 implies MemWrite=0 and Branch=0.
  - {ALUOp1, ALUOp0} is never 2'b11.
- Decode is pure; output depends only on the opcode sampled at the last edge.

## Timing

- Outputs are registered, with 1-cycle latency. `Opcode` is sampled at rising `clk`, and the decoded strobes are valid after that edge until the next edge.
- While `rst_n`=0, all ten outputs are forced to 0 immediately and asynchronously. Note that `Illegal` is 0 in reset, not 1.
- First rising edge after `rst_n` deasserts loads the decode of the current `Opcode`.
- Reset asserted mid-stream clears outputs at once. The opcode presented during reset is discarded, and no stale decode survives.
- An `Opcode` change between edges has no effect on the outputs until the next edge. Back-to-back identical opcodes hold the outputs steady with no glitch.
- No handshake and no stall input; every cycle loads a new decode.

## Structure

- Shared package `mips_pkg`:
  - Opcode constants: OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100.
  - ALU-op class constants: ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_FUNCT=2'b10.
  - A packed control-bundle struct (the nine strobes plus `Illegal`), shared with the datapath and the ALU control block.
- One natural sub-module, `control_decode`. It is purely combinational, maps opcode to the bundle, and its default arm is the illegal/no-op bundle.
- `control_unit` instantiates `control_decode` and adds the async-reset output register.

## Test plan

- Reset: hold `rst_n`=0 with `Opcode`=6'b100011 → all ten outputs 0. Release reset, then one edge → lw pattern 0,1,1,1,1,0,0,0,0,0.
- Sequence R-type, lw, sw, beq, R-type, one per clock → outputs in the following cycles are 1,1,0,0,0,0,0,1,0,0 / 0,1,1,1,1,0,0,0,0,0 / 0,0,1,0,0,1,0,0,0,0 / 0,0,0,0,0,0,1,0,1,0 / 1,1,0,0,0,0,0,1,0,0.
- Illegal opcodes 6'b000010, 6'b111111 and 6'b001000 → all strobes 0, `Illegal`=1.
- Latency check: change `Opcode` mid-cycle from sw to lw → outputs keep the sw pattern until the next rising edge.
- Async reset mid-cycle while the lw decode is held → outputs drop to 0 before any clock edge and stay 0 until an edge after release.
- Sweep all 64 opcodes → all three invariants hold every cycle, and `Illegal`=1 for exactly 60 of them.
